// File: rtl/stream_pkg.sv
// Shared types and defaults for the frame streamer: raster size defaults,
// read-address width and the controller state encoding.
package stream_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;
  localparam int ADDR_W       = 19;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// x/y raster position of the next pixel to present, with x wrap into y and a
// last-pixel flag. The x/y outputs exist only when CROSSHAIR_EN is defined.
module raster_counter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  parameter int YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_en,
`ifdef CROSSHAIR_EN
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
`endif
  output logic          o_last
);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_wrap;
  logic          w_y_wrap;

  assign w_x_wrap = (r_x == XW'(H_ACTIVE - 1));
  assign w_y_wrap = (r_y == YW'(V_ACTIVE - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      if (w_x_wrap) begin
        r_x <= '0;
        r_y <= w_y_wrap ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

`ifdef CROSSHAIR_EN
  assign o_x = r_x;
  assign o_y = r_y;
`endif
  assign o_last = w_x_wrap && w_y_wrap;

endmodule

// File: rtl/frame_streamer.sv
// Streams one frame from a 1-cycle-latency frame buffer to a stallable sink.
// Optional CROSSHAIR_EN overlays a marker row/column in mark_color.
module frame_streamer
  import stream_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              hold,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       data_out,
  output logic              valid,
  output logic              busy,
`ifdef CROSSHAIR_EN
  input  logic [31:0]       mark_x,
  input  logic [31:0]       mark_y,
  input  logic [31:0]       mark_color,
`endif
  output logic              done
);

  localparam int                NPIX      = H_ACTIVE * V_ACTIVE;
  localparam int                XW        = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int                YW        = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_pend;
  logic              r_all_issued;
  logic              r_skid_v;
  logic [31:0]       r_skid;
  logic [31:0]       r_last_pix;
  logic              w_start;
  logic              w_avail;
  logic              w_present;
  logic              w_issue;
  logic              w_last_pix;
  logic [31:0]       w_pix;
  logic [31:0]       w_pix_out;

  // Sink handshake: a pixel transfers in every cycle with valid=1; valid is
  // never 1 while hold=1, and outside transfers data_out keeps the last pixel.
  assign w_avail   = (r_state == ST_STREAM) && (r_skid_v || r_rd_pend);
  assign w_present = w_avail && !hold;
  assign w_pix     = r_skid_v ? r_skid : mem_rdata;

  // A read is issued only if its data can land in an empty skid next cycle.
  assign w_issue = ((r_state == ST_PRIME) || (r_state == ST_STREAM)) &&
                   !r_all_issued && !(w_avail && hold);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s) begin
          w_state_nxt = ST_PRIME;
          w_start     = 1'b1;
        end
      end
      ST_PRIME:  w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_present && w_last_pix) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_rd_pend    <= 1'b0;
      r_all_issued <= 1'b0;
      r_skid_v     <= 1'b0;
      r_skid       <= '0;
      r_last_pix   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_issue;
      if (w_start) begin
        r_addr       <= '0;
        r_all_issued <= 1'b0;
      end else if (w_issue) begin
        if (r_addr == LAST_ADDR) r_all_issued <= 1'b1;
        else                     r_addr       <= r_addr + 1'b1;
      end
      if ((r_state == ST_STREAM) && r_rd_pend && hold) begin
        r_skid_v <= 1'b1;
        r_skid   <= mem_rdata;
      end else if (w_present) begin
        r_skid_v <= 1'b0;
      end
      if (w_present) r_last_pix <= w_pix_out;
    end
  end

`ifdef CROSSHAIR_EN
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [31:0]   r_mark_x;
  logic [31:0]   r_mark_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mark_x <= '0;
      r_mark_y <= '0;
    end else if (w_start) begin
      r_mark_x <= mark_x;
      r_mark_y <= mark_y;
    end
  end

  assign w_pix_out = ((32'(w_x) == r_mark_x) || (32'(w_y) == r_mark_y)) ? mark_color : w_pix;
`else
  assign w_pix_out = w_pix;
`endif

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_raster (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clr   (w_start),
    .i_en    (w_present),
`ifdef CROSSHAIR_EN
    .o_x     (w_x),
    .o_y     (w_y),
`endif
    .o_last  (w_last_pix)
  );

  assign mem_addr = r_addr;
  assign valid    = w_present;
  assign data_out = w_present ? w_pix_out : r_last_pix;
  assign busy     = (r_state == ST_PRIME) || (r_state == ST_STREAM);
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer on a small 8x4 raster; the crosshair
// scenario is compiled in only when CROSSHAIR_EN is defined.
module tb_frame_streamer;
  import stream_pkg::*;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int NPIX = H * V;
  localparam int MAXC = 400;

  logic              clk = 1'b0;
  logic              reset;
  logic              s;
  logic              hold;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic [31:0]       data_out;
  logic              valid;
  logic              busy;
  logic              done;
`ifdef CROSSHAIR_EN
  logic [31:0]       mark_x;
  logic [31:0]       mark_y;
  logic [31:0]       mark_color;
`endif

  int checks   = 0;
  int failures = 0;

  // per-cycle logs of one frame run, indexed from the s cycle
  logic        v_log    [MAXC];
  logic        done_log [MAXC];
  logic        busy_log [MAXC];
  logic [31:0] d_log    [MAXC];
  logic [18:0] a_log    [MAXC];
  int          ncyc;
  int          hv;
  int          hchg;
  int          max_addr;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  frame_streamer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (s),
    .hold       (hold),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .data_out   (data_out),
    .valid      (valid),
    .busy       (busy),
`ifdef CROSSHAIR_EN
    .mark_x     (mark_x),
    .mark_y     (mark_y),
    .mark_color (mark_color),
`endif
    .done       (done)
  );

  function automatic logic [31:0] img(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  // frame buffer: synchronous read, data one cycle after the address
  always @(posedge clk) mem_rdata <= img(int'(mem_addr));

  task automatic fill_exp();
    exp_q.delete();
    for (int k = 0; k < NPIX; k++) begin
`ifdef CROSSHAIR_EN
      if ((k % H) == int'(mark_x) || (k / H) == int'(mark_y)) exp_q.push_back(mark_color);
      else exp_q.push_back(img(k));
`else
      exp_q.push_back(img(k));
`endif
    end
  endtask

  task automatic scan_logs(output int nv, output int first_v, output int last_v,
                           output int nd, output int done_c);
    nv = 0; first_v = -1; last_v = -1; nd = 0; done_c = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (v_log[c]) begin
        nv++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (done_log[c]) begin
        nd++;
        if (done_c < 0) done_c = c;
      end
    end
  endtask

  // mode 0: no hold, 1: random 30% hold, 2: hold over [h_lo,h_hi].
  // Extra s pulses are sent once the given number of pixels has been seen.
  task automatic run_frame(input int mode, input int h_lo, input int h_hi,
                           input int s_px_a, input int s_px_b);
    int npx = 0;
    bit pa = 0;
    bit pb = 0;
    int done_at = -1;
    got_q.delete();
    hv = 0; hchg = 0; max_addr = 0; ncyc = 0;
    @(posedge clk); #1;
    s = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        1:       hold = ($urandom_range(0, 99) < 30);
        2:       hold = (c >= h_lo) && (c <= h_hi);
        default: hold = 1'b0;
      endcase
      if (c > 0) begin
        s = 1'b0;
        if (!pa && s_px_a >= 0 && npx >= s_px_a) begin s = 1'b1; pa = 1; end
        else if (!pb && s_px_b >= 0 && npx >= s_px_b) begin s = 1'b1; pb = 1; end
      end
      @(negedge clk);
      v_log[c] = valid; done_log[c] = done; busy_log[c] = busy;
      d_log[c] = data_out; a_log[c] = mem_addr;
      if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
      if (valid && hold) hv++;
      if (hold && c > 0 && data_out !== d_log[c-1]) hchg++;
      if (valid) begin got_q.push_back(data_out); npx++; end
      if (done && done_at < 0) done_at = c;
      ncyc = c + 1;
      @(posedge clk); #1;
      if (done_at >= 0 && c >= done_at + 2) break;
    end
    s = 1'b0;
    hold = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b1; hold = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL rst_data: got %h want 0", data_out); end
    @(posedge clk); #1;
    reset = 1'b0; s = 1'b0; hold = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_prio_busy: got %b want 0", busy); end
  endtask

  task automatic test_frame_no_hold();
    int nv, fv, lv, nd, dc;
    run_frame(0, 0, 0, -1, -1);
    scan_logs(nv, fv, lv, nd, dc);
    checks++; if (a_log[1] !== '0) begin failures++; $display("FAIL nh_prime_addr: got %0d want 0", a_log[1]); end
    checks++; if (v_log[1] !== 1'b0) begin failures++; $display("FAIL nh_prime_valid: got %b want 0", v_log[1]); end
    checks++; if (busy_log[0] !== 1'b0) begin failures++; $display("FAIL nh_busy_c0: got %b want 0", busy_log[0]); end
    checks++; if (busy_log[1] !== 1'b1) begin failures++; $display("FAIL nh_busy_c1: got %b want 1", busy_log[1]); end
    checks++; if (fv != 2) begin failures++; $display("FAIL nh_first_valid: got %0d want 2", fv); end
    checks++; if (lv != NPIX + 1) begin failures++; $display("FAIL nh_last_valid: got %0d want %0d", lv, NPIX + 1); end
    checks++; if (nv != NPIX) begin failures++; $display("FAIL nh_count: got %0d want %0d", nv, NPIX); end
    checks++; if (dc != NPIX + 2) begin failures++; $display("FAIL nh_done_cycle: got %0d want %0d", dc, NPIX + 2); end
    checks++; if (nd != 1) begin failures++; $display("FAIL nh_done_count: got %0d want 1", nd); end
    checks++; if (busy_log[NPIX+1] !== 1'b1) begin failures++; $display("FAIL nh_busy_last: got %b want 1", busy_log[NPIX+1]); end
    checks++; if (busy_log[NPIX+2] !== 1'b0) begin failures++; $display("FAIL nh_busy_done: got %b want 0", busy_log[NPIX+2]); end
    checks++; if (max_addr > NPIX - 1) begin failures++; $display("FAIL nh_addr_range: got %0d want <= %0d", max_addr, NPIX - 1); end
    fill_exp();
    foreach (got_q[k]) begin
      logic [31:0] e;
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      checks++; if (got_q[k] !== e) begin failures++; $display("FAIL nh_pixel %0d: got %h want %h", k, got_q[k], e); end
    end
  endtask

  task automatic test_hold_stress();
    int nv, fv, lv, nd, dc;
    run_frame(1, 0, 0, -1, -1);
    scan_logs(nv, fv, lv, nd, dc);
    checks++; if (nv != NPIX) begin failures++; $display("FAIL hs_count: got %0d want %0d", nv, NPIX); end
    checks++; if (hv != 0) begin failures++; $display("FAIL hs_valid_in_hold: got %0d want 0", hv); end
    checks++; if (hchg != 0) begin failures++; $display("FAIL hs_data_in_hold: got %0d changes want 0", hchg); end
    checks++; if (nd != 1) begin failures++; $display("FAIL hs_done_count: got %0d want 1", nd); end
    checks++; if (dc != lv + 1) begin failures++; $display("FAIL hs_done_cycle: got %0d want %0d", dc, lv + 1); end
    checks++; if (max_addr > NPIX - 1) begin failures++; $display("FAIL hs_addr_range: got %0d want <= %0d", max_addr, NPIX - 1); end
    fill_exp();
    foreach (got_q[k]) begin
      logic [31:0] e;
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      checks++; if (got_q[k] !== e) begin failures++; $display("FAIL hs_pixel %0d: got %h want %h", k, got_q[k], e); end
    end
  endtask

  task automatic test_hold_last();
    int nv, fv, lv, nd, dc;
    // hold covers the nominal final-pixel cycle and five more
    run_frame(2, NPIX + 1, NPIX + 6, -1, -1);
    scan_logs(nv, fv, lv, nd, dc);
    checks++; if (nv != NPIX) begin failures++; $display("FAIL hl_count: got %0d want %0d", nv, NPIX); end
    checks++; if (lv != NPIX + 7) begin failures++; $display("FAIL hl_last_valid: got %0d want %0d", lv, NPIX + 7); end
    checks++; if (dc != NPIX + 8) begin failures++; $display("FAIL hl_done_cycle: got %0d want %0d", dc, NPIX + 8); end
    checks++; if (nd != 1) begin failures++; $display("FAIL hl_done_count: got %0d want 1", nd); end
    checks++; if (hv != 0) begin failures++; $display("FAIL hl_valid_in_hold: got %0d want 0", hv); end
    fill_exp();
    foreach (got_q[k]) begin
      logic [31:0] e;
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      checks++; if (got_q[k] !== e) begin failures++; $display("FAIL hl_pixel %0d: got %h want %h", k, got_q[k], e); end
    end
  endtask

  task automatic test_s_while_busy();
    int nv, fv, lv, nd, dc;
    run_frame(0, 0, 0, 5, 20);
    scan_logs(nv, fv, lv, nd, dc);
    checks++; if (nv != NPIX) begin failures++; $display("FAIL sb_count: got %0d want %0d", nv, NPIX); end
    checks++; if (nd != 1) begin failures++; $display("FAIL sb_done_count: got %0d want 1", nd); end
    checks++; if (dc != NPIX + 2) begin failures++; $display("FAIL sb_done_cycle: got %0d want %0d", dc, NPIX + 2); end
    fill_exp();
    foreach (got_q[k]) begin
      logic [31:0] e;
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      checks++; if (got_q[k] !== e) begin failures++; $display("FAIL sb_pixel %0d: got %h want %h", k, got_q[k], e); end
    end
  endtask

  task automatic test_reset_mid();
    int nv, fv, lv, nd, dc;
    int seen = 0;
    bit reached = 0;
    @(posedge clk); #1;
    s = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (valid) seen++;
      @(posedge clk); #1;
      s = 1'b0;
      if (seen >= 10) begin reached = 1; break; end
    end
    checks++; if (!reached) begin failures++; $display("FAIL rm_reach: got %0d pixels want 10", seen); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rm_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b want 0", busy); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL rm_addr: got %0d want 0", mem_addr); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL rm_data: got %h want 0", data_out); end
    run_frame(0, 0, 0, -1, -1);
    scan_logs(nv, fv, lv, nd, dc);
    checks++; if (fv != 2) begin failures++; $display("FAIL rm_first_valid: got %0d want 2", fv); end
    checks++; if (nv != NPIX) begin failures++; $display("FAIL rm_count: got %0d want %0d", nv, NPIX); end
    checks++; if (nd != 1) begin failures++; $display("FAIL rm_done_count: got %0d want 1", nd); end
    fill_exp();
    foreach (got_q[k]) begin
      logic [31:0] e;
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      checks++; if (got_q[k] !== e) begin failures++; $display("FAIL rm_pixel %0d: got %h want %h", k, got_q[k], e); end
    end
  endtask

`ifdef CROSSHAIR_EN
  task automatic test_crosshair();
    int nv, fv, lv, nd, dc;
    mark_x = 32'd3; mark_y = 32'd2; mark_color = 32'h00FF0000;
    run_frame(1, 0, 0, -1, -1);
    scan_logs(nv, fv, lv, nd, dc);
    checks++; if (nv != NPIX) begin failures++; $display("FAIL ch_count: got %0d want %0d", nv, NPIX); end
    checks++; if (dc != lv + 1) begin failures++; $display("FAIL ch_done_cycle: got %0d want %0d", dc, lv + 1); end
    fill_exp();
    foreach (got_q[k]) begin
      logic [31:0] e;
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      checks++; if (got_q[k] !== e) begin failures++; $display("FAIL ch_pixel %0d: got %h want %h", k, got_q[k], e); end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; s = 1'b0; hold = 1'b0;
`ifdef CROSSHAIR_EN
    mark_x = 32'hFFFF_FFFF; mark_y = 32'hFFFF_FFFF; mark_color = 32'h0;
`endif
    test_reset();
    test_frame_no_hold();
    test_hold_stress();
    test_hold_last();
    test_s_while_busy();
    test_reset_mid();
`ifdef CROSSHAIR_EN
    test_crosshair();
`endif
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
